// File: rtl/bsg_round_robin_2_to_1_merge.sv
// Two-lane round-robin merge: each lane is buffered in its own FIFO and the
// merged output takes words strictly alternately, starting at lane 0.

// Per-lane FIFO. The storage array has no reset. Pointers and occupancy
// use an asynchronous active-low reset.
module bsg_rr2_lane_fifo #(
  parameter int width_p = 16,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               enq_i,
  input  logic               deq_i,
  input  logic [width_p-1:0] data_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [width_p-1:0] data_o
);
  localparam int PW = $clog2(els_p);
  localparam int CW = PW + 1;

  logic [width_p-1:0] r_mem [els_p];
  logic [PW-1:0]      r_rptr, r_wptr;
  logic [CW-1:0]      r_cnt;

  // Write payload at the write pointer. Storage holds no control meaning.
  always_ff @(posedge clk_i) begin
    if (enq_i) r_mem[r_wptr] <= data_i;
  end

  // Pointers wrap naturally because els_p is a power of two.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (enq_i) r_wptr <= r_wptr + 1'b1;
      if (deq_i) r_rptr <= r_rptr + 1'b1;
      case ({enq_i, deq_i})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign full_o  = (r_cnt == CW'(els_p));
  assign empty_o = (r_cnt == '0);
  assign data_o  = r_mem[r_rptr];
endmodule

module bsg_round_robin_2_to_1_merge #(
  parameter int width_p = 16,
  parameter int els_p   = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [2*width_p-1:0] data_i,
  input  logic [1:0]           v_i,
  output logic [1:0]           ready_o,
  output logic [width_p-1:0]   data_o,
  output logic                 v_o,
  input  logic                 ready_i,
  output logic [15:0]          count_o
);
  logic                       r_head;
  logic [15:0]                r_count;
  logic [1:0]                 w_full, w_empty, w_enq, w_deq;
  logic [1:0][width_p-1:0]    w_head_data;
  logic                       w_xfer;

  // ready_o depends only on occupancy. It is gated by reset so it reads
  // 0 while reset is held.
  assign ready_o = {2{reset_n_i}} & ~w_full;
  assign w_enq   = v_i & ready_o;

  // Only the head lane may present data. Other lanes are never skipped.
  assign v_o     = ~w_empty[r_head];
  assign data_o  = w_head_data[r_head];
  assign w_xfer  = v_o & ready_i;
  assign w_deq   = {w_xfer & r_head, w_xfer & ~r_head};

  for (genvar k = 0; k < 2; k++) begin : g_lane
    bsg_rr2_lane_fifo #(.width_p(width_p), .els_p(els_p)) u_fifo (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .enq_i    (w_enq[k]),
      .deq_i    (w_deq[k]),
      .data_i   (data_i[k*width_p +: width_p]),
      .full_o   (w_full[k]),
      .empty_o  (w_empty[k]),
      .data_o   (w_head_data[k])
    );
  end

  // The head toggles and the wrapping counter advances on each output transfer.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_head  <= 1'b0;
      r_count <= '0;
    end else if (w_xfer) begin
      r_head  <= ~r_head;
      r_count <= r_count + 16'd1;
    end
  end

  assign count_o = r_count;
endmodule
